loteria_sorteador: RTL

LOTERIA_SORTEADOR -- requirements
Module: loteria_sorteador

---
 rtl/loteria_pkg.sv | 29 ++
 rtl/loteria_lfsr.sv | 27 ++
 rtl/loteria_sorteador.sv | 106 ++++++++++
 3 files changed

// File: rtl/loteria_pkg.sv
// Shared definitions for the lottery number drawer: FSM encoding, prize codes
// and the LFSR constants and next-value function.
package loteria_pkg;

  // Legacy-compatible state encoding.
  typedef logic [2:0] estado_t;

  localparam estado_t IDLE     = 3'd0;
  localparam estado_t INSERE   = 3'd1;
  localparam estado_t FIM      = 3'd2;
  localparam estado_t AGUARDA  = 3'd3;
  localparam estado_t FIM_JOGO = 3'd4;

  typedef logic [1:0] premio_t;

  localparam premio_t SEM_PREMIO    = 2'd0;
  localparam premio_t PREMIO_TERNO  = 2'd1;
  localparam premio_t PREMIO_QUADRA = 2'd2;
  localparam premio_t PREMIO_QUINA  = 2'd3;

  localparam logic [7:0] LFSR_RESET = 8'h01;
  // Feedback taps are bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/loteria_lfsr.sv
// 8-bit Fibonacci LFSR.
// A loaded seed takes priority over advancing. An all-zero seed is replaced by
// the reset value so the register can never lock up.
module loteria_lfsr
  import loteria_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       avanca,
  input  logic       carrega,
  input  logic [7:0] semente,
  output logic [7:0] valor
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor <= LFSR_RESET;
    end else if (carrega) begin
      valor <= (semente == 8'h00) ? LFSR_RESET : semente;
    end else if (avanca) begin
      valor <= lfsr_next(valor);
    end
  end

endmodule

// File: rtl/loteria_sorteador.sv
// Game sequencer. Each round sends N_NUMEROS LFSR numbers, then samples the
// prize code returned by the core. A game is N_RODADAS rounds.
module loteria_sorteador
  import loteria_pkg::*;
#(
  parameter int N_NUMEROS = 5,
  parameter int N_RODADAS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       carrega_semente,
  input  logic [7:0] semente,
  input  logic [1:0] premio,
  output logic [3:0] numero,
  output logic       insere,
  output logic       fim,
  output logic       fim_jogo,
  output logic       ocupado,
  output logic [1:0] ultimo_premio,
  output logic [3:0] contador_premios,
  output logic       pronto
);

  localparam logic [3:0] ULTIMO_NUMERO = 4'(N_NUMEROS - 1);
  localparam logic [3:0] TOTAL_RODADAS = 4'(N_RODADAS);

  estado_t    estado;
  estado_t    prox_estado;
  logic [3:0] cnt_numeros;
  logic [3:0] cnt_rodadas;
  logic [7:0] lfsr_valor;
  logic       lfsr_carrega;
  logic       unused_lfsr_msb;

  // The seed is accepted only between games.
  assign lfsr_carrega    = carrega_semente && (estado == IDLE);
  assign unused_lfsr_msb = ^lfsr_valor[7:4];

  loteria_lfsr u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .avanca  (insere),
    .carrega (lfsr_carrega),
    .semente (semente),
    .valor   (lfsr_valor)
  );

  // NOTE: every always_comb output gets a default before the case so that no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    prox_estado = estado;
    case (estado)
      IDLE:     if (start) prox_estado = INSERE;
      INSERE:   if (cnt_numeros == ULTIMO_NUMERO) prox_estado = FIM;
      FIM:      prox_estado = AGUARDA;
      AGUARDA:  prox_estado = (cnt_rodadas < TOTAL_RODADAS) ? INSERE : FIM_JOGO;
      FIM_JOGO: prox_estado = IDLE;
      default:  prox_estado = IDLE;
    endcase
  end

  // cnt_rodadas counts finished rounds. It advances on leaving FIM, so
  // AGUARDA already sees the current round as done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado           <= IDLE;
      cnt_numeros      <= 4'd0;
      cnt_rodadas      <= 4'd0;
      ultimo_premio    <= SEM_PREMIO;
      contador_premios <= 4'd0;
    end else begin
      estado <= prox_estado;
      case (estado)
        IDLE: begin
          if (start) begin
            cnt_numeros      <= 4'd0;
            cnt_rodadas      <= 4'd0;
            contador_premios <= 4'd0;
          end
        end
        INSERE: begin
          cnt_numeros <= (cnt_numeros == ULTIMO_NUMERO) ? 4'd0 : cnt_numeros + 4'd1;
        end
        FIM: begin
          cnt_rodadas <= cnt_rodadas + 4'd1;
        end
        AGUARDA: begin
          ultimo_premio <= premio;
          if ((premio != SEM_PREMIO) && (contador_premios != 4'hF))
            contador_premios <= contador_premios + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Strobes are decoded from the registered state only.
  assign insere   = (estado == INSERE);
  assign fim      = (estado == FIM);
  assign fim_jogo = (estado == FIM_JOGO);
  assign pronto   = (estado == FIM_JOGO);
  assign ocupado  = (estado != IDLE);
  assign numero   = insere ? lfsr_valor[3:0] : 4'd0;

endmodule
